pc_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 10 +
 rtl/pc_sequencer_if.sv | 16 +
 rtl/pc_sequencer_br_cond_eval.sv | 10 +
 rtl/pc_sequencer.sv | 77 +++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared opcode constants and sequencer state encoding for the PC sequencer.
package cpu_pkg;
  localparam int OP_W = 6;
  localparam logic [OP_W-1:0] OP_BR_FIRST = 6'd15;
  localparam logic [OP_W-1:0] OP_BR_LAST  = 6'd20;
  localparam logic [OP_W-1:0] OP_JMP      = 6'd21;
  localparam logic [OP_W-1:0] OP_HALT     = 6'd63;

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, UPDATE, HALT} state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch and execute handshake between the sequencer and memory/datapath.
interface pc_sequencer_if #(parameter int PC_W = 32);
  logic                     imem_req;
  logic [PC_W-1:0]          imem_addr;
  logic                     imem_ack;
  logic                     instr_valid;
  logic                     ex_done;
  logic [cpu_pkg::OP_W-1:0] op;
  logic                     zero;
  logic [PC_W-1:0]          target;

  modport master (output imem_req, imem_addr, instr_valid,
                  input  imem_ack, ex_done, op, zero, target);
  modport slave  (input  imem_req, imem_addr, instr_valid,
                  output imem_ack, ex_done, op, zero, target);
endinterface

// File: rtl/pc_sequencer_br_cond_eval.sv
// Branch decision from the captured opcode and zero flag.
module br_cond_eval import cpu_pkg::*; (
  input  logic [OP_W-1:0] op,
  input  logic            zero,
  output logic            take,
  output logic            is_halt
);
  assign is_halt = (op == OP_HALT);
  assign take    = ((op >= OP_BR_FIRST) && (op <= OP_BR_LAST) && zero) || (op == OP_JMP);
endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: fetch, wait for execute, resolve branch, load next PC.
module pc_sequencer import cpu_pkg::*; #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  pc_sequencer_if.master  bus,
  output logic [PC_W-1:0] pc,
  output logic            br_taken,
  output logic            busy,
  output logic            halted
);
  localparam logic [PC_W-1:0] STEP_V = PC_W'(PC_STEP);

  state_t          state, state_nxt;
  logic [OP_W-1:0] op_q;
  logic            zero_q;
  logic [PC_W-1:0] tgt_q;
  logic            req_q, iv_q;
  logic            take, is_halt;

  br_cond_eval u_br (
    .op      (op_q),
    .zero    (zero_q),
    .take    (take),
    .is_halt (is_halt)
  );

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = iv_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)        state_nxt = FETCH;
      FETCH:   if (bus.imem_ack) state_nxt = EXEC;
      EXEC:    if (bus.ex_done)  state_nxt = UPDATE;
      UPDATE:  state_nxt = is_halt ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      op_q     <= '0;
      zero_q   <= 1'b0;
      tgt_q    <= '0;
      req_q    <= 1'b0;
      iv_q     <= 1'b0;
      br_taken <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == EXEC && bus.ex_done) begin
        op_q   <= bus.op;
        zero_q <= bus.zero;
        tgt_q  <= bus.target;
      end
      if (state == UPDATE && !is_halt)
        pc <= take ? tgt_q : pc + STEP_V;
      req_q    <= (state_nxt == FETCH);
      iv_q     <= (state == FETCH) && bus.imem_ack;
      br_taken <= (state == UPDATE) && take && !is_halt;
      busy     <= (state_nxt == FETCH) || (state_nxt == EXEC) || (state_nxt == UPDATE);
      halted   <= (state_nxt == HALT);
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of two sequencers (RESET_PC 0 and all-ones) driven in lockstep.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic        exd = 1'b0;
  logic [5:0]  op = '0;
  logic        zero = 1'b0;
  logic [31:0] target = '0;

  logic [31:0] pc0, pc1;
  logic        br0, br1, busy0, busy1, halted0, halted1;
  logic [31:0] mpc0, mpc1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(32)) sif0 ();
  pc_sequencer_if #(.PC_W(32)) sif1 ();

  assign sif0.imem_ack = ack;  assign sif1.imem_ack = ack;
  assign sif0.ex_done  = exd;  assign sif1.ex_done  = exd;
  assign sif0.op       = op;   assign sif1.op       = op;
  assign sif0.zero     = zero; assign sif1.zero     = zero;
  assign sif0.target   = target; assign sif1.target = target;

  pc_sequencer #(.PC_W(32), .RESET_PC(32'h0), .PC_STEP(1)) dut0 (
    .clk(clk), .rstn(rstn), .start(start), .bus(sif0),
    .pc(pc0), .br_taken(br0), .busy(busy0), .halted(halted0));

  pc_sequencer #(.PC_W(32), .RESET_PC(32'hFFFF_FFFF), .PC_STEP(1)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .bus(sif1),
    .pc(pc1), .br_taken(br1), .busy(busy1), .halted(halted1));

  task automatic ck(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ck_idle_reset();
    ck("rst_pc0", pc0, 32'h0);
    ck("rst_pc1", pc1, 32'hFFFF_FFFF);
    ck("rst_req", {sif0.imem_req, sif1.imem_req}, 0);
    ck("rst_iv", {sif0.instr_valid, sif1.instr_valid}, 0);
    ck("rst_br", {br0, br1}, 0);
    ck("rst_busy", {busy0, busy1}, 0);
    ck("rst_halt", {halted0, halted1}, 0);
  endtask

  // Entered with both sequencers in FETCH; leaves them one cycle after UPDATE.
  task automatic run_instr(input logic [5:0] o, input logic z, input logic [31:0] t,
                           input int ad, input int ed, input logic sp);
    logic tk, hlt;
    ck("fetch_req", {sif0.imem_req, sif1.imem_req}, 2'b11);
    ck("fetch_addr0", sif0.imem_addr, mpc0);
    ck("fetch_addr1", sif1.imem_addr, mpc1);
    ck("fetch_busy", busy0, 1);
    for (int i = 0; i < ad; i++) begin
      ack = 1'b0; exd = sp; start = sp;
      step();
      ck("req_hold", sif0.imem_req, 1);
      ck("addr_hold", sif0.imem_addr, mpc0);
      ck("iv_wait", sif0.instr_valid, 0);
    end
    exd = 1'b0; start = 1'b0; ack = 1'b1;
    step();
    ack = 1'b0;
    ck("iv_pulse", {sif0.instr_valid, sif1.instr_valid}, 2'b11);
    ck("req_drop", sif0.imem_req, 0);
    for (int i = 0; i < ed; i++) begin
      ack = sp;
      step();
      ck("iv_once", sif0.instr_valid, 0);
      ck("exec_req", sif0.imem_req, 0);
      ck("exec_pc", pc0, mpc0);
    end
    ack = 1'b0; op = o; zero = z; target = t; exd = 1'b1;
    step();
    exd = 1'b0; op = 6'($urandom); zero = 1'($urandom); target = $urandom;
    ck("upd_br", br0, 0);
    ck("upd_pc", pc0, mpc0);
    ck("upd_busy", busy0, 1);
    ck("upd_iv", sif0.instr_valid, 0);
    step();
    hlt = (o == 6'd63);
    tk  = (o == 6'd21) || (o >= 6'd15 && o <= 6'd20 && z);
    if (!hlt) begin
      mpc0 = tk ? t : mpc0 + 32'd1;
      mpc1 = tk ? t : mpc1 + 32'd1;
    end
    ck("pc0", pc0, mpc0);
    ck("pc1", pc1, mpc1);
    ck("br_taken", {br0, br1}, {tk, tk});
    ck("halted", halted0, hlt);
    ck("busy_next", busy0, !hlt);
    ck("req_next", sif0.imem_req, !hlt);
  endtask

  initial begin
    logic [5:0] ro;
    #1 rstn = 1'b0;
    #10;
    ck_idle_reset();
    @(negedge clk) rstn = 1'b1;
    step();
    ack = 1'b1; exd = 1'b1;
    step();
    ack = 1'b0; exd = 1'b0;
    ck_idle_reset();

    mpc0 = 32'h0; mpc1 = 32'hFFFF_FFFF;
    start = 1'b1;
    step();
    start = 1'b0;

    for (int i = 0; i < 3; i++) run_instr(6'd0, 1'b0, 32'h55, 0, 0, 1'b0);
    ck("pc_after3", pc0, 32'd3);
    run_instr(6'd0, 1'b1, 32'h55, 0, 0, 1'b0);
    run_instr(6'd0, 1'b0, 32'h55, 0, 0, 1'b0);
    run_instr(6'd15, 1'b1, 32'h40, 0, 0, 1'b0);
    run_instr(6'd21, 1'b0, 32'h5, 0, 0, 1'b0);
    run_instr(6'd20, 1'b1, 32'h40, 0, 0, 1'b0);
    run_instr(6'd21, 1'b0, 32'h5, 0, 0, 1'b0);
    run_instr(6'd18, 1'b0, 32'h40, 0, 0, 1'b0);
    run_instr(6'd21, 1'b0, 32'h80, 0, 0, 1'b0);
    run_instr(6'd0, 1'b0, 32'h0, 4, 2, 1'b1);
    run_instr(6'd21, 1'b0, 32'h80, 1, 1, 1'b0);
    run_instr(6'd17, 1'b1, 32'h80, 0, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       ro = 6'($urandom_range(0, 14));
        1:       ro = 6'($urandom_range(15, 20));
        2:       ro = 6'd21;
        default: ro = 6'($urandom_range(22, 62));
      endcase
      run_instr(ro, 1'($urandom), $urandom, $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom));
    end

    run_instr(6'd63, 1'b1, 32'h1234, 1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; exd = 1'b1; ack = 1'b1; op = 6'd21; target = 32'h77;
      step();
      ck("halt_stay", {halted0, halted1}, 2'b11);
      ck("halt_pc0", pc0, mpc0);
      ck("halt_pc1", pc1, mpc1);
      ck("halt_busy", busy0, 0);
      ck("halt_req", sif0.imem_req, 0);
    end
    start = 1'b0; exd = 1'b0; ack = 1'b0;

    // Reset out of HALT, then abort mid-EXEC with an asynchronous reset.
    rstn = 1'b0;
    #1;
    ck_idle_reset();
    @(negedge clk) rstn = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0; ack = 1'b1;
    step();
    ack = 1'b0;
    ck("exec_entered", busy0, 1);
    #2 rstn = 1'b0;
    #1;
    ck_idle_reset();
    @(negedge clk) rstn = 1'b1;
    exd = 1'b1; ack = 1'b1; op = 6'd21; target = 32'h99; zero = 1'b1;
    step();
    step();
    exd = 1'b0; ack = 1'b0;
    ck_idle_reset();

    mpc0 = 32'h0; mpc1 = 32'hFFFF_FFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr(6'd0, 1'b0, 32'h0, 0, 0, 1'b0);
    run_instr(6'd16, 1'b1, 32'h0, 2, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
